// File: rtl/lane_stats_seq.sv
// lane_stats_seq -- sequential lane statistics accelerator.
//
// Captures a, b and c on a start handshake, then walks the N_LANES lanes of
// a and b one lane per cycle. When the last lane has been processed it
// publishes four results and pulses done for one cycle:
//   x : maximum lane of a (unsigned; signed when LANE_STATS_SIGNED_MAX_EN)
//   y : XOR over all lanes of (a_i & b_i)
//   z : number of ones in c
//   w : XOR-reduce of ((c ^ (b_{N-1} & a_0)) | MASK)
// Results hold until the next completion.
//
// Optional build macro: LANE_STATS_SIGNED_MAX_EN selects a two's-complement
// comparison for x. Everything else is identical in both builds.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, accepted only while idle
//   a, b   in   N_LANES*LANE_W operands, lane 0 in the LSBs
//   c      in   LANE_W operand
//   busy   out  high while an operation is in progress
//   done   out  one-cycle pulse when x/y/z/w update
//   x, y   out  LANE_W results
//   z      out  popcount of c
//   w      out  masked parity bit
module lane_stats_seq #(
    parameter int                N_LANES = 2,
    parameter int                LANE_W  = 8,
    parameter logic [LANE_W-1:0] MASK    = LANE_W'('hAA)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [N_LANES*LANE_W-1:0]      a,
    input  logic [N_LANES*LANE_W-1:0]      b,
    input  logic [LANE_W-1:0]              c,
    output logic                           busy,
    output logic                           done,
    output logic [LANE_W-1:0]              x,
    output logic [LANE_W-1:0]              y,
    output logic [$clog2(LANE_W+1)-1:0]    z,
    output logic                           w
);

    localparam int ZW    = $clog2(LANE_W + 1);
    localparam int IDX_W = $clog2(N_LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LANES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                    state_q, state_d;
    logic [N_LANES*LANE_W-1:0] a_q, a_d;
    logic [N_LANES*LANE_W-1:0] b_q, b_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [LANE_W-1:0]         max_q, max_d;
    logic [LANE_W-1:0]         yacc_q, yacc_d;
    logic [ZW-1:0]             zhold_q, zhold_d;
    logic                      whold_q, whold_d;
    logic [LANE_W-1:0]         x_q, x_d;
    logic [LANE_W-1:0]         y_q, y_d;
    logic [ZW-1:0]             z_q, z_d;
    logic                      w_q, w_d;
    logic                      done_q, done_d;

    logic [LANE_W-1:0] lane_a, lane_b;
    logic [LANE_W-1:0] max_new, y_new;
    logic              lane_gt;
    logic [ZW-1:0]     pop_c;
    logic              w_new;

    // Per-lane datapath for the lane currently indexed in RUN.
    always_comb begin
        lane_a = a_q[int'(idx_q)*LANE_W +: LANE_W];
        lane_b = b_q[int'(idx_q)*LANE_W +: LANE_W];
`ifdef LANE_STATS_SIGNED_MAX_EN
        lane_gt = $signed(lane_a) > $signed(max_q);
`else
        lane_gt = lane_a > max_q;
`endif
        // Strict compare: on a tie the earlier lane is kept.
        max_new = (idx_q == '0 || lane_gt) ? lane_a : max_q;
        y_new   = (idx_q == '0) ? (lane_a & lane_b) : (yacc_q ^ (lane_a & lane_b));
    end

    // z and w depend only on the operands, so they are computed from the
    // live inputs at capture time and parked until completion.
    always_comb begin
        pop_c = '0;
        for (int i = 0; i < LANE_W; i++) begin
            pop_c = pop_c + ZW'(c[i]);
        end
        w_new = ^((c ^ (b[(N_LANES-1)*LANE_W +: LANE_W] & a[LANE_W-1:0])) | MASK);
    end

    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        max_d   = max_q;
        yacc_d  = yacc_q;
        zhold_d = zhold_q;
        whold_d = whold_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        w_d     = w_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    zhold_d = pop_c;
                    whold_d = w_new;
                    state_d = RUN;
                end
            end
            RUN: begin
                max_d  = max_new;
                yacc_d = y_new;
                if (idx_q == LAST_IDX) begin
                    x_d     = max_new;
                    y_d     = y_new;
                    z_d     = zhold_q;
                    w_d     = whold_q;
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            max_q   <= '0;
            yacc_q  <= '0;
            zhold_q <= '0;
            whold_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            w_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            max_q   <= max_d;
            yacc_q  <= yacc_d;
            zhold_q <= zhold_d;
            whold_q <= whold_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            w_q     <= w_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign x    = x_q;
    assign y    = y_q;
    assign z    = z_q;
    assign w    = w_q;

endmodule

// File: tb/tb_lane_stats_seq.sv
// Directed testbench for lane_stats_seq: one instance with N_LANES=2 and one
// with N_LANES=4, both LANE_W=8, MASK=8'hAA. Inputs are driven 1 time unit
// after the rising edge and outputs are sampled at the same point.
module tb_lane_stats_seq;

    logic clk;
    logic rst_n;

    // N_LANES = 2 instance
    logic        s2_start;
    logic [15:0] s2_a, s2_b;
    logic [7:0]  s2_c;
    logic        s2_busy, s2_done, s2_w;
    logic [7:0]  s2_x, s2_y;
    logic [3:0]  s2_z;

    // N_LANES = 4 instance
    logic        s4_start;
    logic [31:0] s4_a, s4_b;
    logic [7:0]  s4_c;
    logic        s4_busy, s4_done, s4_w;
    logic [7:0]  s4_x, s4_y;
    logic [3:0]  s4_z;

    int n_cmp = 0;
    int n_err = 0;

    lane_stats_seq #(.N_LANES(2), .LANE_W(8), .MASK(8'hAA)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(s2_start),
        .a(s2_a), .b(s2_b), .c(s2_c),
        .busy(s2_busy), .done(s2_done),
        .x(s2_x), .y(s2_y), .z(s2_z), .w(s2_w)
    );

    lane_stats_seq #(.N_LANES(4), .LANE_W(8), .MASK(8'hAA)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(s4_start),
        .a(s4_a), .b(s4_b), .c(s4_c),
        .busy(s4_busy), .done(s4_done),
        .x(s4_x), .y(s4_y), .z(s4_z), .w(s4_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check2(input string tag, input logic ebusy, input logic edone,
                          input logic [7:0] ex, input logic [7:0] ey,
                          input logic [3:0] ez, input logic ew);
        check({tag, ".busy"}, 32'(s2_busy), 32'(ebusy));
        check({tag, ".done"}, 32'(s2_done), 32'(edone));
        check({tag, ".x"},    32'(s2_x),    32'(ex));
        check({tag, ".y"},    32'(s2_y),    32'(ey));
        check({tag, ".z"},    32'(s2_z),    32'(ez));
        check({tag, ".w"},    32'(s2_w),    32'(ew));
    endtask

    initial begin
        logic [7:0] exp_x2;
        logic [7:0] exp_x4;

`ifdef LANE_STATS_SIGNED_MAX_EN
        exp_x2 = 8'h7F;
        exp_x4 = 8'h20;
`else
        exp_x2 = 8'h80;
        exp_x4 = 8'hFE;
`endif

        rst_n    = 1'b0;
        s2_start = 1'b0; s2_a = '0; s2_b = '0; s2_c = '0;
        s4_start = 1'b0; s4_a = '0; s4_b = '0; s4_c = '0;
        #12;
        check2("reset", 1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0);
        check("reset4.busy", 32'(s4_busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Test 1: basic operation, N_LANES=2
        s2_a = 16'h3C7F; s2_b = 16'hFF0F; s2_c = 8'hB5; s2_start = 1'b1;
        tick();
        s2_start = 1'b0;
        check2("t1.e0", 1'b1, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0);
        tick();
        check2("t1.e1", 1'b1, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0);
        tick();
        check2("t1.e2", 1'b0, 1'b1, 8'h7F, 8'h33, 4'd5, 1'b1);
        tick();
        check2("t1.e3", 1'b0, 1'b0, 8'h7F, 8'h33, 4'd5, 1'b1);

        // Test 6: input changes without start leave everything alone
        for (int k = 0; k < 5; k++) begin
            s2_a = 16'h1234 + 16'(k * 16'h1111);
            s2_b = 16'hA5A5 ^ 16'(k);
            s2_c = 8'h0F + 8'(k);
            tick();
            check2("t6.hold", 1'b0, 1'b0, 8'h7F, 8'h33, 4'd5, 1'b1);
        end

        // Test 2: unsigned vs signed maximum
        s2_a = 16'h807F; s2_b = 16'h0000; s2_c = 8'h00; s2_start = 1'b1;
        tick();
        s2_start = 1'b0;
        tick();
        tick();
        check2("t2.done", 1'b0, 1'b1, exp_x2, 8'h00, 4'd0, 1'b0);

        // Test 3: reset in the middle of an operation
        s2_a = 16'h3C7F; s2_b = 16'hFF0F; s2_c = 8'hB5; s2_start = 1'b1;
        tick();
        s2_start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check2("t3.rst", 1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check2("t3.nodone", 1'b0, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0);
        end
        s2_start = 1'b1;
        tick();
        s2_start = 1'b0;
        tick();
        tick();
        check2("t3.after", 1'b0, 1'b1, 8'h7F, 8'h33, 4'd5, 1'b1);

        // Test 4: N_LANES=4, start during RUN ignored
        s4_a = 32'h01FE1020; s4_b = 32'hFFFFFFFF; s4_c = 8'hFF; s4_start = 1'b1;
        tick();
        check("t4.e0.busy", 32'(s4_busy), 32'd1);
        s4_a = 32'h7F7F7F7F; s4_b = 32'h0; s4_c = 8'h01;
        tick();
        s4_start = 1'b0;
        check("t4.e1.busy", 32'(s4_busy), 32'd1);
        tick();
        tick();
        check("t4.e3.busy", 32'(s4_busy), 32'd1);
        check("t4.e3.done", 32'(s4_done), 32'd0);
        tick();
        check("t4.e4.busy", 32'(s4_busy), 32'd0);
        check("t4.e4.done", 32'(s4_done), 32'd1);
        check("t4.x", 32'(s4_x), 32'(exp_x4));
        check("t4.y", 32'(s4_y), 32'hCF);
        check("t4.z", 32'(s4_z), 32'd8);
        check("t4.w", 32'(s4_w), 32'd0);
        tick();
        check("t4.e5.busy", 32'(s4_busy), 32'd0);
        check("t4.e5.done", 32'(s4_done), 32'd0);

        // Test 5: start held high, back-to-back operations every 3 cycles
        s2_a = 16'h3C7F; s2_b = 16'hFF0F; s2_c = 8'hB5; s2_start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("t5.done", 32'(s2_done), ((k % 3) == 0) ? 32'd1 : 32'd0);
            check("t5.x", 32'(s2_x), (k < 3) ? 32'h7F : 32'h7F);
            check("t5.y", 32'(s2_y), 32'h33);
            check("t5.z", 32'(s2_z), 32'd5);
            check("t5.w", 32'(s2_w), 32'd1);
        end
        s2_start = 1'b0;
        tick();
        tick();
        check2("t5.drain", 1'b0, 1'b1, 8'h7F, 8'h33, 4'd5, 1'b1);
        tick();
        check2("t5.idle", 1'b0, 1'b0, 8'h7F, 8'h33, 4'd5, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
